sync_fifo_vr: RTL and testbench

Parametrised synchronous FIFO with a native valid/ready handshake on both sides. It is the successor of the fixed 8-bit enable-style FIFO plus its handshake wrapper.
Adds configurable width and depth, first-word-fall-through output, an occupancy count, programmable almost-full/almost-empty flags, and a synchronous flush.
Used as the standard elastic buffer between streaming stages in a single clock domain.

---
 rtl/fifo_pkg.sv | 21 ++
 rtl/fifo_mem.sv | 18 +
 rtl/sync_fifo_vr.sv | 61 ++++++
 tb/tb_sync_fifo_vr.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared helpers and status type for the streaming FIFO family.
package fifo_pkg;
    localparam int STATUS_CW = 16;
    typedef struct packed {
        logic [STATUS_CW-1:0] count;
        logic                 almost_full;
        logic                 almost_empty;
        logic                 full;
        logic                 empty;
    } fifo_status_t;
    function automatic int count_w(input int depth);
        return $clog2(depth + 1);
    endfunction
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction
    // Explicit wrap so non-power-of-2 depths work.
    function automatic int ptr_inc(input int ptr, input int depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction
endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: DEPTH x WIDTH register array, synchronous write, asynchronous read, no reset.
module fifo_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int PW    = 4
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [PW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [PW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    always_ff @(posedge clk)
        if (i_we) r_mem[i_waddr] <= i_wdata;
    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/sync_fifo_vr.sv
// sync_fifo_vr: FWFT synchronous FIFO with valid/ready on both sides,
// occupancy count, registered almost flags and synchronous flush.
module sync_fifo_vr import fifo_pkg::*; #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    parameter int CW       = count_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush,
    input  logic             valid_w,
    output logic             ready_w,
    input  logic [WIDTH-1:0] data_w,
    output logic             valid_r,
    input  logic             ready_r,
    output logic [WIDTH-1:0] data_r,
    output logic [CW-1:0]    count,
    output logic             almost_full,
    output logic             almost_empty
);
    localparam int PW = ptr_w(DEPTH);
    logic [PW-1:0] r_wr_ptr, r_rd_ptr;
    logic [CW-1:0] r_count, w_count_nxt;
    logic          r_af, r_ae, w_wr, w_rd;
    assign ready_w      = r_count != CW'(DEPTH);
    assign valid_r      = r_count != '0;
    assign count        = r_count;
    assign almost_full  = r_af;
    assign almost_empty = r_ae;
    assign w_wr = valid_w && ready_w && !flush;
    assign w_rd = valid_r && ready_r && !flush;
    always_comb
        w_count_nxt = flush           ? '0 :
                      (w_wr && !w_rd) ? r_count + 1'b1 :
                      (w_rd && !w_wr) ? r_count - 1'b1 : r_count;
    // Flags follow the next-state count so they line up with count.
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_af     <= 1'b0;
            r_ae     <= 1'b1;
        end else begin
            r_wr_ptr <= flush ? '0 : w_wr ? PW'(ptr_inc(32'(r_wr_ptr), DEPTH)) : r_wr_ptr;
            r_rd_ptr <= flush ? '0 : w_rd ? PW'(ptr_inc(32'(r_rd_ptr), DEPTH)) : r_rd_ptr;
            r_count  <= w_count_nxt;
            r_af     <= w_count_nxt >= CW'(AF_LEVEL);
            r_ae     <= w_count_nxt <= CW'(AE_LEVEL);
        end
    fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PW(PW)) u_mem (
        .clk     (clk),
        .i_we    (w_wr),
        .i_waddr (r_wr_ptr),
        .i_wdata (data_w),
        .i_raddr (r_rd_ptr),
        .o_rdata (data_r)
    );
endmodule

// File: tb/tb_sync_fifo_vr.sv
// tb_sync_fifo_vr: queue-model checks for a DEPTH=4 and a DEPTH=3 FIFO plus directed literals.
module tb_sync_fifo_vr;
    logic clk = 1'b0, rstn = 1'b0;
    always #5 clk = ~clk;
    logic       v4 = 0, r4 = 0, f4 = 0, rw4, vr4, af4, ae4;
    logic [7:0] d4 = 0, dr4;
    logic [2:0] cnt4;
    logic       v3 = 0, r3 = 0, f3 = 0, rw3, vr3, af3, ae3;
    logic [7:0] d3 = 0, dr3;
    logic [1:0] cnt3;
    int n_chk = 0, n_err = 0;
    logic [7:0] q4[$], q3[$];
    logic [7:0] got[$];

    sync_fifo_vr #(.WIDTH(8), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(2)) u4 (
        .clk(clk), .rstn(rstn), .flush(f4), .valid_w(v4), .ready_w(rw4), .data_w(d4),
        .valid_r(vr4), .ready_r(r4), .data_r(dr4), .count(cnt4),
        .almost_full(af4), .almost_empty(ae4));
    sync_fifo_vr #(.WIDTH(8), .DEPTH(3), .AF_LEVEL(1), .AE_LEVEL(2)) u3 (
        .clk(clk), .rstn(rstn), .flush(f3), .valid_w(v3), .ready_w(rw3), .data_w(d3),
        .valid_r(vr3), .ready_r(r3), .data_r(dr3), .count(cnt3),
        .almost_full(af3), .almost_empty(ae3));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: queue contents per the transfer rules.
    always @(posedge clk or negedge rstn)
        if (!rstn) begin
            q4.delete();
            q3.delete();
        end else begin
            logic w, r;
            w = v4 && q4.size() < 4 && !f4;
            r = r4 && q4.size() > 0 && !f4;
            if (f4) q4.delete();
            else begin
                if (r) void'(q4.pop_front());
                if (w) q4.push_back(d4);
            end
            w = v3 && q3.size() < 3 && !f3;
            r = r3 && q3.size() > 0 && !f3;
            if (f3) q3.delete();
            else begin
                if (r) void'(q3.pop_front());
                if (w) q3.push_back(d3);
            end
        end

    always @(negedge clk)
        if (rstn) begin
            chk("cnt4", 32'(cnt4), q4.size());
            chk("valid_r4", 32'(vr4), 32'(q4.size() != 0));
            chk("ready_w4", 32'(rw4), 32'(q4.size() != 4));
            chk("af4", 32'(af4), 32'(q4.size() >= 3));
            chk("ae4", 32'(ae4), 32'(q4.size() <= 2));
            if (q4.size() != 0) chk("data_r4", 32'(dr4), 32'(q4[0]));
            chk("cnt3", 32'(cnt3), q3.size());
            chk("valid_r3", 32'(vr3), 32'(q3.size() != 0));
            chk("ready_w3", 32'(rw3), 32'(q3.size() != 3));
            chk("af3", 32'(af3), 32'(q3.size() >= 1));
            chk("ae3", 32'(ae3), 32'(q3.size() <= 2));
            if (q3.size() != 0) chk("data_r3", 32'(dr3), 32'(q3[0]));
        end

    task automatic step4(input logic v, input logic [7:0] d, input logic r, input logic f);
        v4 = v; d4 = d; r4 = r; f4 = f;
        @(posedge clk); #1;
    endtask

    task automatic step3(input logic v, input logic [7:0] d, input logic r);
        v3 = v; d3 = d; r3 = r;
        if (vr3 && r3) got.push_back(dr3);
        @(posedge clk); #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        chk("rst_ready_w", 32'(rw4), 1);
        chk("rst_valid_r", 32'(vr4), 0);
        chk("rst_count", 32'(cnt4), 0);
        chk("rst_ae", 32'(ae4), 1);
        chk("rst_af", 32'(af4), 0);
        step4(0, 8'h00, 0, 0);
        // Fill with the consumer stalled.
        step4(1, 8'hA1, 0, 0);
        step4(1, 8'hA2, 0, 0);
        chk("fill2_af", 32'(af4), 0);
        step4(1, 8'hA3, 0, 0);
        chk("fill3_cnt", 32'(cnt4), 3);
        chk("fill3_af", 32'(af4), 1);
        step4(1, 8'hA4, 0, 0);
        chk("full_cnt", 32'(cnt4), 4);
        chk("full_ready_w", 32'(rw4), 0);
        step4(1, 8'hA5, 0, 0);
        chk("reject_cnt", 32'(cnt4), 4);
        chk("reject_head", 32'(dr4), 32'hA1);
        // Drain in order.
        v4 = 0; r4 = 1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_data", 32'(dr4), 32'(8'hA1 + 8'(i)));
            step4(0, 8'h00, 1, 0);
        end
        chk("drain_valid_r", 32'(vr4), 0);
        chk("drain_cnt", 32'(cnt4), 0);
        // Full with simultaneous read and write.
        for (int i = 0; i < 4; i++) step4(1, 8'hB0 + 8'(i), 0, 0);
        step4(1, 8'hBF, 1, 0);
        chk("fullrw_cnt", 32'(cnt4), 3);
        chk("fullrw_ready_w", 32'(rw4), 1);
        chk("fullrw_head", 32'(dr4), 32'hB1);
        step4(0, 8'h00, 1, 0);
        chk("pre_flush_cnt", 32'(cnt4), 2);
        // Flush beats a concurrent write.
        step4(1, 8'hCC, 0, 1);
        chk("flush_cnt", 32'(cnt4), 0);
        chk("flush_valid_r", 32'(vr4), 0);
        chk("flush_ae", 32'(ae4), 1);
        step4(1, 8'hD1, 0, 0);
        step4(1, 8'hD2, 0, 0);
        chk("refill_head", 32'(dr4), 32'hD1);
        chk("refill_cnt", 32'(cnt4), 2);
        step4(0, 8'h00, 0, 0);
        // Async reset between edges.
        rstn = 1'b0;
        #1;
        chk("areset_cnt", 32'(cnt4), 0);
        chk("areset_valid_r", 32'(vr4), 0);
        chk("areset_ready_w", 32'(rw4), 1);
        #1 rstn = 1'b1;
        step4(0, 8'h00, 0, 0);
        // Non-power-of-2 depth streaming with continuous handshake.
        for (int i = 0; i < 10; i++) begin
            step3(1, 8'h30 + 8'(i), 1);
            if (i >= 1) chk("stream_cnt3", 32'(cnt3), 1);
        end
        step3(0, 8'h00, 1);
        step3(0, 8'h00, 1);
        chk("stream_len", got.size(), 10);
        for (int i = 0; i < got.size(); i++) chk("stream_order", 32'(got[i]), 32'(8'h30 + 8'(i)));
        chk("stream_empty", 32'(vr3), 0);
        // Fill DEPTH=3 to exercise the 2->0 wrap at full.
        for (int i = 0; i < 4; i++) step3(1, 8'h40 + 8'(i), 0);
        chk("d3_full_cnt", 32'(cnt3), 3);
        chk("d3_full_ready_w", 32'(rw3), 0);
        step3(0, 8'h00, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
